// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared DIV opcode and divider state encodings for the 2432 execute stage
package div_seq_pkg;
    localparam logic [5:0] OP_DIV = 6'h1b;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration
module div_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] prem,
    input  logic             msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] prem_next,
    output logic             qbit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    // the full partial remainder is shifted so divisors above 2^(WIDTH-1) still divide correctly
    always_comb begin
        shifted   = {prem, msb};
        trial     = shifted - {1'b0, divisor};
        qbit      = ~trial[WIDTH];
        prem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle signed/unsigned restoring divider, one quotient bit per clock
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             vout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic qneg_q, qneg_d, rneg_q, rneg_d, ovf_q, ovf_d;
    logic dbz_q, dbz_d, vout_q, vout_d;
    logic [WIDTH-1:0] prem_nx;
    logic qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem_q),
        .msb       (dvd_q[WIDTH-1]),
        .divisor   (dvs_q),
        .prem_next (prem_nx),
        .qbit      (qbit)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        vout_d  = vout_q;
        case (state_q)
            DIV_IDLE: if (start) begin
                qneg_d  = signed_op & (din_a[WIDTH-1] ^ din_b[WIDTH-1]);
                rneg_d  = signed_op & din_a[WIDTH-1];
                ovf_d   = signed_op & (din_a == MOST_NEG) & (din_b == '1);
                dvd_d   = (signed_op & din_a[WIDTH-1]) ? -din_a : din_a;
                dvs_d   = (signed_op & din_b[WIDTH-1]) ? -din_b : din_b;
                prem_d  = '0;
                count_d = CW'(WIDTH - 1);
                state_d = (din_b == '0) ? DIV_DONE : DIV_CALC;
                if (din_b == '0) begin
                    quo_d  = '1;
                    rem_d  = din_a;
                    dbz_d  = 1'b1;
                    vout_d = 1'b0;
                end
            end
            DIV_CALC: begin
                prem_d  = prem_nx;
                dvd_d   = {dvd_q[WIDTH-2:0], qbit};
                count_d = (count_q == '0) ? count_q : count_q - 1'b1;
                state_d = (count_q == '0) ? DIV_FIX : DIV_CALC;
            end
            DIV_FIX: begin
                quo_d   = qneg_q ? -dvd_q : dvd_q;
                rem_d   = rneg_q ? -prem_q : prem_q;
                dbz_d   = 1'b0;
                vout_d  = ovf_q;
                state_d = DIV_DONE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            vout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            vout_q  <= vout_d;
        end
    end

    assign busy      = (state_q == DIV_CALC) || (state_q == DIV_FIX);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;
    assign vout      = vout_q;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed scoreboard bench for div_seq (WIDTH=32)
module tb_div_seq;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        vout;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] din_a = '0;
    logic [31:0] din_b = '0;
    logic        busy, done, dbz, vout;
    logic [31:0] quotient, remainder;

    exp_t sb[$];
    exp_t got;
    int cyc = 0;
    int nchk = 0;
    int nfail = 0;
    int bf = 1;
    int bt = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .din_a     (din_a),
        .din_b     (din_b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .vout      (vout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // monitor: busy window every cycle, results popped from the scoreboard on done
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(cyc >= bf && cyc <= bt));
        if (done) begin
            if (sb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                got = sb.pop_front();
                chk("quotient", quotient, got.q);
                chk("remainder", remainder, got.r);
                chk("dbz", 32'(dbz), 32'(got.dbz));
                chk("vout", 32'(vout), 32'(got.vout));
                chk("done_cycle", 32'(cyc), 32'(got.cyc));
            end
        end
    end

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ed, input logic ev);
        exp_t e;
        @(negedge clk);
        e.q = eq;
        e.r = er;
        e.dbz = ed;
        e.vout = ev;
        e.cyc = cyc + (ed ? 1 : 34);
        sb.push_back(e);
        if (ed) begin
            bf = 1;
            bt = 0;
        end else begin
            bf = cyc + 1;
            bt = cyc + 33;
        end
        start = 1'b1;
        signed_op = s;
        din_a = a;
        din_b = b;
        @(negedge clk);
        start = 1'b0;
        signed_op = 1'($urandom);
        din_a = $urandom;
        din_b = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        nchk++;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL done_timeout: %0d results outstanding at cycle %0d", sb.size(), cyc);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_quotient", quotient, 32'h0);
        chk("rst_remainder", remainder, 32'h0);
        chk("rst_flags", {28'h0, busy, done, dbz, vout}, 32'h0);
        reset = 1'b0;

        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        wait_idle();
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_idle();
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        wait_idle();
        issue(1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0);
        wait_idle();
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b1);
        wait_idle();
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        wait_idle();
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        wait_idle();
        issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);
        wait_idle();
        issue(1'b1, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0);
        wait_idle();

        // a second start in cycle 10 must be dropped; the follow-up lands in cycle 35
        issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        start = 1'b1;
        signed_op = 1'b0;
        din_a = 32'd5;
        din_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        issue(1'b0, 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF, 1'b0, 1'b0);
        wait_idle();

        // abort mid-operation with reset in cycle 15
        issue(1'b0, 32'd500, 32'd3, 32'd166, 32'd2, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        bt = cyc;
        @(negedge clk);
        chk("abort_quotient", quotient, 32'h0);
        chk("abort_remainder", remainder, 32'h0);
        chk("abort_flags", {28'h0, busy, done, dbz, vout}, 32'h0);
        reset = 1'b0;
        issue(1'b0, 32'd500, 32'd3, 32'd166, 32'd2, 1'b0, 1'b0);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
